// File: rtl/seq_detect_param.sv
// Serial pattern detector: matches a qualified bit stream against a programmable
// PAT_W-bit pattern, with overlap control, a saturating match counter and a registered match.
module seq_detect_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_load_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic             overlap_i,
    input  logic             valid_i,
    input  logic             data_i,
    input  logic             clear_i,
    output logic             match_o,
    output logic             match_q_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             cnt_sat_o
);

    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  pat_q;
    logic              ovl_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sat_q;
    logic              match_q;

    logic              accept;
    logic              full;
    logic [PAT_W-1:0]  window;
    logic [CNT_W-1:0]  cnt_inc;

    // window is the candidate pattern: stored history followed by the current bit
    assign accept  = valid_i & ~cfg_load_i & ~clear_i;
    assign full    = (fill == FILL_FULL);
    assign window  = {hist, data_i};
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Gated by rst_i so the combinational match drops the moment reset asserts.
    assign match_o = rst_i & accept & full & (window == pat_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hist    <= '0;
            fill    <= '0;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            match_q <= match_o;
            if (cfg_load_i) begin
                pat_q <= pattern_i;
                ovl_q <= overlap_i;
                hist  <= '0;
                fill  <= '0;
            end
            if (clear_i) begin
                hist  <= '0;
                fill  <= '0;
                cnt_q <= '0;
                sat_q <= 1'b0;
            end else if (accept) begin
                if (match_o && !ovl_q) begin
                    // Non-overlapping: the matched bits cannot seed the next match.
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= window[PAT_W-2:0];
                    if (!full) begin
                        fill <= fill + FILL_W'(1);
                    end
                end
                if (match_o && !(&cnt_q)) begin
                    cnt_q <= cnt_inc;
                    if (&cnt_inc) begin
                        sat_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign match_q_o   = match_q;
    assign match_cnt_o = cnt_q;
    assign cnt_sat_o   = sat_q;

endmodule
